// File: rtl/fetch_queue.sv
// fetch_queue: decoupled instruction-fetch unit.
//   Owns the fetch PC, issues sequential requests to a synchronous instruction memory
//   (data one cycle after the request) and buffers {pc, instr} pairs in a DEPTH-entry
//   FIFO feeding decode. A redirect flushes everything and restarts fetch at the target.
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   imem_req/imem_addr      memory request and word-aligned byte address
//   imem_rdata              memory data, valid the cycle after imem_req
//   redirect/redirect_pc    flush and restart at redirect_pc (low two bits ignored)
//   id_ready                decode accepts the head entry this cycle
//   out_valid/out_pc/out_instr  head entry
//   count                   occupied FIFO entries
// Optional feature: define FETCH_QUEUE_BYPASS_EN to forward a response straight to the
//   outputs when the FIFO is empty (one cycle less request-to-valid latency).
module fetch_queue #(
  parameter int unsigned     PC_W     = 9,
  parameter int unsigned     INS_W    = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [PC_W-1:0]          imem_addr,
  input  logic [INS_W-1:0]         imem_rdata,
  input  logic                     redirect,
  input  logic [PC_W-1:0]          redirect_pc,
  input  logic                     id_ready,
  output logic                     out_valid,
  output logic [PC_W-1:0]          out_pc,
  output logic [INS_W-1:0]         out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic             pending_q, pending_d;
  logic [PC_W-1:0]  pend_pc_q, pend_pc_d;

  logic [PC_W-1:0]  mem_pc_q    [DEPTH];
  logic [INS_W-1:0] mem_instr_q [DEPTH];

  logic head_valid, byp_valid, push, pop;

  assign head_valid = (count_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp_valid = !head_valid && pending_q && !redirect;
`else
  assign byp_valid = 1'b0;
`endif

  // Entries in flight count against FIFO space, so a response always has a slot.
  assign imem_req  = !reset && !redirect && ((count_q + CntW'(pending_q)) < CntW'(DEPTH));
  assign imem_addr = fetch_pc_q;

  assign pop  = head_valid && id_ready && !redirect;
  // A bypassed response that decode takes immediately never enters the FIFO.
  assign push = pending_q && !redirect && !(byp_valid && id_ready);

  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (!reset) begin
      if (head_valid) begin
        out_valid = 1'b1;
        out_pc    = mem_pc_q[rd_ptr_q];
        out_instr = mem_instr_q[rd_ptr_q];
      end else if (byp_valid) begin
        out_valid = 1'b1;
        out_pc    = pend_pc_q;
        out_instr = imem_rdata;
      end
    end
  end

  assign count = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    pending_d  = imem_req;
    pend_pc_d  = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = {redirect_pc[PC_W-1:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      pending_d  = 1'b0;
    end else begin
      if (imem_req) fetch_pc_d = fetch_pc_q + PC_W'(4);
      if (push)     wr_ptr_d   = wr_ptr_q + PtrW'(1);
      if (pop)      rd_ptr_d   = rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_d = count_q + CntW'(1);
      else if (pop && !push) count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= {RESET_PC[PC_W-1:2], 2'b00};
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pending_q  <= 1'b0;
      pend_pc_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pending_q  <= pending_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_pc_q[wr_ptr_q]    <= pend_pc_q;
      mem_instr_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (default parameters: PC_W=9, DEPTH=4, RESET_PC=0).
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_pc = '0;
  logic        id_ready = 1'b1;
  logic        out_valid;
  logic [8:0]  out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_pc;

  fetch_queue dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .count      (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [8:0] a);
    return {16'hC0DE, 7'h00, a};
  endfunction

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk) imem_rdata <= imem_req ? word(imem_addr) : 32'hDEAD_BEEF;

  // Drive inputs just after the falling edge, then let outputs settle.
  task automatic cyc(input logic rs, input logic rd, input logic [8:0] rpc, input logic idr);
    @(negedge clk);
    reset = rs; redirect = rd; redirect_pc = rpc; id_ready = idr;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 9'h0, 1'b1);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (out_pc !== 9'h0) begin fails++; $display("FAIL reset_pc: got %h want 000", out_pc); end
    tests++; if (out_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
  endtask

  task automatic test_stream;
    int first_req = -1;
    int first_val = -1;
    exp_pc = 9'h0;
    for (int c = 0; c < 10; c++) begin
      cyc(1'b0, 1'b0, 9'h0, 1'b1);
      if (c == 0) begin
        tests++; if (imem_addr !== 9'h0) begin fails++; $display("FAIL first_addr: got %h want 000", imem_addr); end
      end
      if (imem_req && first_req < 0) first_req = c;
      if (out_valid) begin
        if (first_val < 0) first_val = c;
        tests++;
        if (out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
          fails++; $display("FAIL stream_pc: got %h/%h want %h/%h", out_pc, out_instr, exp_pc, word(exp_pc));
        end
        exp_pc = exp_pc + 9'd4;
      end
    end
    tests++; if (first_req !== 0) begin fails++; $display("FAIL first_req_cycle: got %0d want 0", first_req); end
    tests++;
    if (first_val !== (Byp ? 1 : 2)) begin
      fails++; $display("FAIL first_valid_cycle: got %0d want %0d", first_val, Byp ? 1 : 2);
    end
    tests++;
    if (exp_pc !== (Byp ? 9'd36 : 9'd32)) begin
      fails++; $display("FAIL stream_rate: next pc %h want %h", exp_pc, Byp ? 9'd36 : 9'd32);
    end
  endtask

  task automatic test_stall;
    for (int c = 0; c < 10; c++) cyc(1'b0, 1'b0, 9'h0, 1'b0);
    tests++; if (count !== 3'd4) begin fails++; $display("FAIL stall_count: got %0d want 4", count); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req: got %b want 0", imem_req); end
    tests++; if (out_pc !== exp_pc) begin fails++; $display("FAIL stall_head: got %h want %h", out_pc, exp_pc); end
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, 1'b0, 9'h0, 1'b1);
      tests++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
        fails++; $display("FAIL release_pc: got v=%b %h want %h", out_valid, out_pc, exp_pc);
      end
      exp_pc = exp_pc + 9'd4;
    end
  endtask

  // Stall until count reaches 3 (one response still in flight).
  task automatic fill_to_three;
    bit hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      cyc(1'b0, 1'b0, 9'h0, 1'b0);
      if (count == 3'd3) hit = 1'b1;
    end
    tests++; if (!hit) begin fails++; $display("FAIL fill_timeout: count %0d want 3", count); end
  endtask

  task automatic test_redirect;
    cyc(1'b1, 1'b0, 9'h0, 1'b0);
    fill_to_three();
    cyc(1'b0, 1'b1, 9'h043, 1'b0);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL redir_req: got %b want 0", imem_req); end
    cyc(1'b0, 1'b0, 9'h0, 1'b1);
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL redir_count: got %0d want 0", count); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h040) begin
      fails++; $display("FAIL redir_addr: got %b/%h want 1/040", imem_req, imem_addr);
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL redir_valid: got %b want 0", out_valid); end
    exp_pc = 9'h040;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, 9'h0, 1'b1);
      if (out_valid) begin
        tests++;
        if (out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
          fails++; $display("FAIL redir_seq: got %h want %h", out_pc, exp_pc);
        end
        exp_pc = exp_pc + 9'd4;
      end
    end
    tests++;
    if (exp_pc !== (Byp ? 9'h04C : 9'h048)) begin
      fails++; $display("FAIL redir_latency: next pc %h want %h", exp_pc, Byp ? 9'h04C : 9'h048);
    end
  endtask

  task automatic test_wrap;
    logic [8:0] exp_addr;
    cyc(1'b0, 1'b1, 9'h1F8, 1'b1);
    exp_pc   = 9'h1F8;
    exp_addr = 9'h1F8;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, 9'h0, 1'b1);
      if (k < 3) begin
        tests++;
        if (imem_addr !== exp_addr) begin
          fails++; $display("FAIL wrap_addr: got %h want %h", imem_addr, exp_addr);
        end
        exp_addr = exp_addr + 9'd4;
      end
      if (out_valid) begin
        tests++;
        if (out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
          fails++; $display("FAIL wrap_seq: got %h want %h", out_pc, exp_pc);
        end
        exp_pc = exp_pc + 9'd4;
      end
    end
    tests++;
    if (exp_pc !== (Byp ? 9'h00C : 9'h008)) begin
      fails++; $display("FAIL wrap_count: next pc %h want %h", exp_pc, Byp ? 9'h00C : 9'h008);
    end
  endtask

  task automatic test_reset_mid;
    fill_to_three();
    cyc(1'b1, 1'b0, 9'h0, 1'b0);
    tests++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin
      fails++; $display("FAIL midreset_out: got v=%b req=%b want 0/0", out_valid, imem_req);
    end
    cyc(1'b0, 1'b0, 9'h0, 1'b1);
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL midreset_flush: got count=%0d v=%b want 0/0", count, out_valid);
    end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 9'h000) begin
      fails++; $display("FAIL midreset_addr: got %b/%h want 1/000", imem_req, imem_addr);
    end
    exp_pc = 9'h000;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b0, 1'b0, 9'h0, 1'b1);
      if (out_valid) begin
        tests++;
        if (out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
          fails++; $display("FAIL midreset_seq: got %h want %h", out_pc, exp_pc);
        end
        exp_pc = exp_pc + 9'd4;
      end
    end
    tests++;
    if (exp_pc !== (Byp ? 9'h00C : 9'h008)) begin
      fails++; $display("FAIL midreset_latency: next pc %h want %h", exp_pc, Byp ? 9'h00C : 9'h008);
    end
  endtask

  // Random id_ready and redirects against a cycle model of count/pending/fetch PC.
  task automatic test_random;
    int         cnt = 0;
    bit         pend = 1'b0;
    logic [8:0] fpc = 9'h000;
    bit         rd, idr, req_m, byp_m, pop_m, push_m;
    logic [8:0] rpc;
    cyc(1'b1, 1'b0, 9'h0, 1'b1);
    exp_pc = 9'h000;
    for (int c = 0; c < 10000; c++) begin
      rd  = ($urandom_range(0, 63) == 0);
      rpc = 9'($urandom_range(0, 511));
      idr = ($urandom_range(0, 3) != 0);
      cyc(1'b0, rd, rpc, idr);
      req_m  = !rd && (cnt + int'(pend) < 4);
      byp_m  = Byp && cnt == 0 && pend && !rd;
      pop_m  = cnt != 0 && idr && !rd;
      push_m = pend && !rd && !(byp_m && idr);
      tests++; if (imem_req !== req_m) begin fails++; $display("FAIL rnd_req @%0d: got %b want %b", c, imem_req, req_m); end
      tests++; if (count !== 3'(cnt)) begin fails++; $display("FAIL rnd_count @%0d: got %0d want %0d", c, count, cnt); end
      tests++;
      if (out_valid !== (cnt != 0 || byp_m)) begin
        fails++; $display("FAIL rnd_valid @%0d: got %b want %b", c, out_valid, cnt != 0 || byp_m);
      end
      if (req_m) begin
        tests++; if (imem_addr !== fpc) begin fails++; $display("FAIL rnd_addr @%0d: got %h want %h", c, imem_addr, fpc); end
      end
      if (pop_m || (byp_m && idr)) begin
        tests++;
        if (out_pc !== exp_pc || out_instr !== word(exp_pc)) begin
          fails++; $display("FAIL rnd_order @%0d: got %h/%h want %h", c, out_pc, out_instr, exp_pc);
        end
        exp_pc = exp_pc + 9'd4;
      end
      if (rd) begin
        cnt = 0; pend = 1'b0; fpc = {rpc[8:2], 2'b00}; exp_pc = fpc;
      end else begin
        cnt  = cnt + int'(push_m) - int'(pop_m);
        pend = req_m;
        if (req_m) fpc = fpc + 9'd4;
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
